// File: rtl/vga_pkg.sv
// Shared constants for the pitch raster: timing totals, active-region bounds,
// update-FSM state encoding and the committed-position bundle.
package vga_pkg;

    localparam int POS_W = 10;

    localparam int CLK_DIV      = 2;
    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;
    localparam int V_ACTIVE_END = 515;

    localparam int H_ACTIVE_START = 144;
    localparam int H_ACTIVE_END   = 784;
    localparam int V_ACTIVE_START = 35;

    localparam int RST_TEAM1_POS = 275;
    localparam int RST_TEAM2_POS = 275;
    localparam int RST_BALL_X    = 400;
    localparam int RST_BALL_Y    = 275;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_BLANK = 2'd1;
    localparam logic [1:0] ST_GRANT      = 2'd2;
    localparam logic [1:0] ST_COMMIT     = 2'd3;

    typedef struct packed {
        logic [POS_W-1:0] team1;
        logic [POS_W-1:0] team2;
        logic [POS_W-1:0] ball_x;
        logic [POS_W-1:0] ball_y;
    } pos_t;

    function automatic logic in_update_window(input logic [POS_W-1:0] y,
                                              input logic [POS_W-1:0] v_end);
        return (y >= v_end);
    endfunction

endpackage

// File: rtl/vga_scan_counter.sv
// Pixel-clock divider plus x/y raster counters; also flags the frame wrap
// combinationally (for the update FSM) and as a registered frame_start pulse.
module vga_scan_counter
    import vga_pkg::*;
#(
    parameter int P_CLK_DIV = CLK_DIV,
    parameter int P_H_TOTAL = H_TOTAL,
    parameter int P_V_TOTAL = V_TOTAL
) (
    input  logic             clk,
    input  logic             rst,
    output logic             o_pix_en,
    output logic [POS_W-1:0] o_x,
    output logic [POS_W-1:0] o_y,
    output logic             o_frame_start,
    output logic             o_frame_wrap
);

    localparam int DIV_W = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(P_CLK_DIV - 1);
    localparam logic [POS_W-1:0] X_LAST   = POS_W'(P_H_TOTAL - 1);
    localparam logic [POS_W-1:0] Y_LAST   = POS_W'(P_V_TOTAL - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_pix_en;
    logic [POS_W-1:0] r_x;
    logic [POS_W-1:0] r_y;
    logic             r_frame_start;

    logic [DIV_W-1:0] w_div_next;
    logic             w_line_wrap;
    logic             w_frame_wrap;

    assign w_div_next   = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    assign w_line_wrap  = r_pix_en && (r_x == X_LAST);
    assign w_frame_wrap = w_line_wrap && (r_y == Y_LAST);

    // pix_en is registered from the next divider value so it is high exactly
    // while r_div sits at its last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div         <= '0;
            r_pix_en      <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_next;
            r_pix_en      <= (w_div_next == DIV_LAST);
            r_frame_start <= w_frame_wrap;
            if (r_pix_en) begin
                if (w_line_wrap) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    assign o_pix_en      = r_pix_en;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_frame_start = r_frame_start;
    assign o_frame_wrap  = w_frame_wrap;

endmodule

// File: rtl/vga_frame_scheduler.sv
// Raster sequencer and vblank-only position update arbiter: game logic gets a
// grant inside vertical blanking and commits at most one position set per frame.
module vga_frame_scheduler
    import vga_pkg::*;
#(
    parameter int CLK_DIV       = vga_pkg::CLK_DIV,
    parameter int H_TOTAL       = vga_pkg::H_TOTAL,
    parameter int V_TOTAL       = vga_pkg::V_TOTAL,
    parameter int V_ACTIVE_END  = vga_pkg::V_ACTIVE_END,
    parameter int RST_TEAM1_POS = vga_pkg::RST_TEAM1_POS,
    parameter int RST_TEAM2_POS = vga_pkg::RST_TEAM2_POS,
    parameter int RST_BALL_X    = vga_pkg::RST_BALL_X,
    parameter int RST_BALL_Y    = vga_pkg::RST_BALL_Y
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y,
    output logic             frame_start,
    input  logic             upd_req,
    output logic             upd_grant,
    input  logic             upd_done,
    output logic             upd_ack,
    input  logic [POS_W-1:0] team1_in,
    input  logic [POS_W-1:0] team2_in,
    input  logic [POS_W-1:0] ball_x_in,
    input  logic [POS_W-1:0] ball_y_in,
    output logic [POS_W-1:0] team1_ver_pos,
    output logic [POS_W-1:0] team2_ver_pos,
    output logic [POS_W-1:0] ball_x,
    output logic [POS_W-1:0] ball_y
);

    localparam logic [POS_W-1:0] V_END = POS_W'(V_ACTIVE_END);
    localparam pos_t RST_POS = '{
        team1:  POS_W'(RST_TEAM1_POS),
        team2:  POS_W'(RST_TEAM2_POS),
        ball_x: POS_W'(RST_BALL_X),
        ball_y: POS_W'(RST_BALL_Y)
    };

    logic [POS_W-1:0] w_y;
    logic             w_frame_wrap;

    vga_scan_counter #(
        .P_CLK_DIV (CLK_DIV),
        .P_H_TOTAL (H_TOTAL),
        .P_V_TOTAL (V_TOTAL)
    ) u_scan (
        .clk           (clk),
        .rst           (rst),
        .o_pix_en      (pix_en),
        .o_x           (x),
        .o_y           (w_y),
        .o_frame_start (frame_start),
        .o_frame_wrap  (w_frame_wrap)
    );

    assign y = w_y;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       w_commit;
    logic       r_frame_committed;
    pos_t       r_pos;

    // A grant never opens on the wrap edge itself, otherwise it would span the
    // whole next active region.
    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (upd_req) w_state_next = ST_WAIT_BLANK;
            end
            ST_WAIT_BLANK: begin
                if (!upd_req)
                    w_state_next = ST_IDLE;
                else if (in_update_window(w_y, V_END) && !r_frame_committed && !w_frame_wrap)
                    w_state_next = ST_GRANT;
            end
            ST_GRANT: begin
                if (upd_done) begin
                    w_state_next = ST_COMMIT;
                    w_commit     = 1'b1;
                end else if (w_frame_wrap) begin
                    w_state_next = ST_WAIT_BLANK;
                end
            end
            ST_COMMIT: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // The per-frame commit flag clears on the wrap even if a commit lands on
    // that same edge, since that commit belongs to the frame just ending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_frame_committed <= 1'b0;
            r_pos             <= RST_POS;
        end else begin
            r_state <= w_state_next;
            if (w_frame_wrap)
                r_frame_committed <= 1'b0;
            else if (w_commit)
                r_frame_committed <= 1'b1;
            if (w_commit) begin
                r_pos.team1  <= team1_in;
                r_pos.team2  <= team2_in;
                r_pos.ball_x <= ball_x_in;
                r_pos.ball_y <= ball_y_in;
            end
        end
    end

    assign upd_grant     = (r_state == ST_GRANT);
    assign upd_ack       = (r_state == ST_COMMIT);
    assign team1_ver_pos = r_pos.team1;
    assign team2_ver_pos = r_pos.team2;
    assign ball_x        = r_pos.ball_x;
    assign ball_y        = r_pos.ball_y;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench for vga_frame_scheduler on a shrunken raster (10x8 pixels,
// vblank from line 6, 2 clk per pixel) so each frame is only 160 clk.
module tb_vga_frame_scheduler;

    localparam int TB_H    = 10;
    localparam int TB_V    = 8;
    localparam int TB_VEND = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic [9:0] x, y;
    logic       frame_start;
    logic       upd_req, upd_grant, upd_done, upd_ack;
    logic [9:0] team1_in, team2_in, ball_x_in, ball_y_in;
    logic [9:0] team1_ver_pos, team2_ver_pos, ball_x, ball_y;

    int errors = 0;
    int checks = 0;

    vga_frame_scheduler #(
        .CLK_DIV      (2),
        .H_TOTAL      (TB_H),
        .V_TOTAL      (TB_V),
        .V_ACTIVE_END (TB_VEND)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pix_en        (pix_en),
        .x             (x),
        .y             (y),
        .frame_start   (frame_start),
        .upd_req       (upd_req),
        .upd_grant     (upd_grant),
        .upd_done      (upd_done),
        .upd_ack       (upd_ack),
        .team1_in      (team1_in),
        .team2_in      (team2_in),
        .ball_x_in     (ball_x_in),
        .ball_y_in     (ball_y_in),
        .team1_ver_pos (team1_ver_pos),
        .team2_ver_pos (team2_ver_pos),
        .ball_x        (ball_x),
        .ball_y        (ball_y)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_scan(input logic [9:0] tx, input logic [9:0] ty, input bit need_pix,
                             input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (x == tx && y == ty && (!need_pix || pix_en)) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_grant(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (upd_grant) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        logic       exp_pix, exp_fs;
        logic [9:0] exp_x, exp_y;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (x !== 10'd0 || y !== 10'd0) begin errors++; $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", x, y); end
        checks++; if (pix_en !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL reset_strobes: got pix_en=%b frame_start=%b expected 0 0", pix_en, frame_start); end
        checks++; if (upd_grant !== 1'b0 || upd_ack !== 1'b0) begin errors++; $display("FAIL reset_handshake: got grant=%b ack=%b expected 0 0", upd_grant, upd_ack); end
        checks++; if (team1_ver_pos !== 10'd275 || team2_ver_pos !== 10'd275 || ball_x !== 10'd400 || ball_y !== 10'd275) begin
            errors++; $display("FAIL reset_pos: got %0d/%0d/%0d/%0d expected 275/275/400/275", team1_ver_pos, team2_ver_pos, ball_x, ball_y);
        end
        $display("reset: held 3 clk, pos=%0d/%0d/%0d/%0d", team1_ver_pos, team2_ver_pos, ball_x, ball_y);
        rst = 1'b0;
        // k counts clk edges after release; one full small frame plus margin
        for (int k = 1; k <= 200; k++) begin
            tick();
            exp_pix = (k % 2 == 1);
            exp_x   = 10'((k / 2) % TB_H);
            exp_y   = 10'((k / (2 * TB_H)) % TB_V);
            exp_fs  = (k == 2 * TB_H * TB_V);
            checks++; if (pix_en !== exp_pix) begin errors++; $display("FAIL scan_pix_en k=%0d: got %b expected %b", k, pix_en, exp_pix); end
            checks++; if (x !== exp_x || y !== exp_y) begin errors++; $display("FAIL scan_xy k=%0d: got %0d,%0d expected %0d,%0d", k, x, y, exp_x, exp_y); end
            checks++; if (frame_start !== exp_fs) begin errors++; $display("FAIL scan_frame_start k=%0d: got %b expected %b", k, frame_start, exp_fs); end
        end
        $display("scan: 200 clk after release, now x=%0d y=%0d", x, y);
    endtask

    task automatic test_commit();
        bit ok;
        upd_req = 1'b1;
        wait_scan(10'd0, 10'd5, 1'b0, 400, ok);
        checks++; if (!ok || upd_grant !== 1'b0) begin errors++; $display("FAIL commit_no_early_grant: reached=%0d grant=%b expected reached=1 grant=0", ok, upd_grant); end
        wait_grant(400, ok);
        checks++; if (!ok || y !== 10'd6 || x !== 10'd0) begin errors++; $display("FAIL commit_grant_at_vblank: reached=%0d x=%0d y=%0d expected 1 0 6", ok, x, y); end
        team1_in = 10'd60; team2_in = 10'd70; ball_x_in = 10'd80; ball_y_in = 10'd90;
        upd_done = 1'b1;
        tick();
        upd_done = 1'b0;
        checks++; if (team1_ver_pos !== 10'd60 || team2_ver_pos !== 10'd70 || ball_x !== 10'd80 || ball_y !== 10'd90) begin
            errors++; $display("FAIL commit_pos: got %0d/%0d/%0d/%0d expected 60/70/80/90", team1_ver_pos, team2_ver_pos, ball_x, ball_y);
        end
        checks++; if (upd_ack !== 1'b1 || upd_grant !== 1'b0) begin errors++; $display("FAIL commit_ack: got ack=%b grant=%b expected 1 0", upd_ack, upd_grant); end
        tick();
        checks++; if (upd_ack !== 1'b0) begin errors++; $display("FAIL commit_ack_single: got ack=%b expected 0", upd_ack); end
        // req stays high: no second grant in the same vblank
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (upd_grant !== 1'b0) begin errors++; $display("FAIL commit_one_per_frame i=%0d: got grant=%b y=%0d expected 0", i, upd_grant, y); end
        end
        wait_grant(400, ok);
        checks++; if (!ok || y !== 10'd6) begin errors++; $display("FAIL commit_next_frame_grant: reached=%0d y=%0d expected 1 6", ok, y); end
        $display("commit: pos=%0d/%0d/%0d/%0d, re-grant at y=%0d", team1_ver_pos, team2_ver_pos, ball_x, ball_y, y);
    endtask

    task automatic test_wrap_abort();
        bit ok;
        wait_scan(10'd0, 10'd0, 1'b0, 400, ok);
        checks++; if (!ok || upd_grant !== 1'b0) begin errors++; $display("FAIL abort_grant_drop: reached=%0d grant=%b expected 1 0", ok, upd_grant); end
        checks++; if (team1_ver_pos !== 10'd60 || team2_ver_pos !== 10'd70 || ball_x !== 10'd80 || ball_y !== 10'd90 || upd_ack !== 1'b0) begin
            errors++; $display("FAIL abort_pos_kept: got %0d/%0d/%0d/%0d ack=%b expected 60/70/80/90 0", team1_ver_pos, team2_ver_pos, ball_x, ball_y, upd_ack);
        end
        wait_grant(400, ok);
        checks++; if (!ok || y !== 10'd6) begin errors++; $display("FAIL abort_regrant: reached=%0d y=%0d expected 1 6", ok, y); end
        $display("abort: grant dropped at wrap, re-grant at y=%0d", y);
    endtask

    task automatic test_done_at_wrap();
        bit ok;
        wait_scan(10'd9, 10'd7, 1'b1, 400, ok);
        checks++; if (!ok || upd_grant !== 1'b1) begin errors++; $display("FAIL wrap_setup: reached=%0d grant=%b expected 1 1", ok, upd_grant); end
        team1_in = 10'd11; team2_in = 10'd22; ball_x_in = 10'd33; ball_y_in = 10'd44;
        upd_done = 1'b1;
        tick();
        upd_done = 1'b0;
        upd_req  = 1'b0;
        checks++; if (x !== 10'd0 || y !== 10'd0 || frame_start !== 1'b1) begin errors++; $display("FAIL wrap_edge: got x=%0d y=%0d fs=%b expected 0 0 1", x, y, frame_start); end
        checks++; if (upd_ack !== 1'b1) begin errors++; $display("FAIL wrap_ack: got %b expected 1", upd_ack); end
        checks++; if (team1_ver_pos !== 10'd11 || team2_ver_pos !== 10'd22 || ball_x !== 10'd33 || ball_y !== 10'd44) begin
            errors++; $display("FAIL wrap_commit_pos: got %0d/%0d/%0d/%0d expected 11/22/33/44", team1_ver_pos, team2_ver_pos, ball_x, ball_y);
        end
        tick();
        checks++; if (upd_ack !== 1'b0) begin errors++; $display("FAIL wrap_ack_single: got %b expected 0", upd_ack); end
        $display("done_at_wrap: pos=%0d/%0d/%0d/%0d", team1_ver_pos, team2_ver_pos, ball_x, ball_y);
    endtask

    task automatic test_stray_done();
        bit ok;
        wait_scan(10'd0, 10'd2, 1'b0, 400, ok);
        checks++; if (!ok || upd_grant !== 1'b0) begin errors++; $display("FAIL stray_setup: reached=%0d grant=%b expected 1 0", ok, upd_grant); end
        team1_in = 10'd1; team2_in = 10'd2; ball_x_in = 10'd3; ball_y_in = 10'd4;
        upd_done = 1'b1;
        tick();
        upd_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (upd_ack !== 1'b0 || team1_ver_pos !== 10'd11 || team2_ver_pos !== 10'd22 || ball_x !== 10'd33 || ball_y !== 10'd44) begin
                errors++; $display("FAIL stray_ignored i=%0d: ack=%b pos=%0d/%0d/%0d/%0d expected 0 11/22/33/44", i, upd_ack, team1_ver_pos, team2_ver_pos, ball_x, ball_y);
            end
            tick();
        end
        $display("stray_done: ignored, pos=%0d/%0d/%0d/%0d", team1_ver_pos, team2_ver_pos, ball_x, ball_y);
    endtask

    task automatic test_reset_in_grant();
        bit ok;
        upd_req = 1'b1;
        wait_grant(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_grant_setup: grant not seen, got 0 expected 1"); end
        team1_in = 10'd500; team2_in = 10'd501; ball_x_in = 10'd502; ball_y_in = 10'd503;
        rst = 1'b1;
        upd_done = 1'b1;
        tick();
        upd_done = 1'b0;
        upd_req  = 1'b0;
        checks++; if (team1_ver_pos !== 10'd275 || team2_ver_pos !== 10'd275 || ball_x !== 10'd400 || ball_y !== 10'd275) begin
            errors++; $display("FAIL rst_grant_pos: got %0d/%0d/%0d/%0d expected 275/275/400/275", team1_ver_pos, team2_ver_pos, ball_x, ball_y);
        end
        checks++; if (x !== 10'd0 || y !== 10'd0 || upd_grant !== 1'b0 || upd_ack !== 1'b0) begin
            errors++; $display("FAIL rst_grant_state: got x=%0d y=%0d grant=%b ack=%b expected 0 0 0 0", x, y, upd_grant, upd_ack);
        end
        rst = 1'b0;
        tick();
        checks++; if (upd_ack !== 1'b0 || team1_ver_pos !== 10'd275) begin errors++; $display("FAIL rst_grant_no_commit: ack=%b team1=%0d expected 0 275", upd_ack, team1_ver_pos); end
        $display("reset_in_grant: pos=%0d/%0d/%0d/%0d", team1_ver_pos, team2_ver_pos, ball_x, ball_y);
    endtask

    initial begin
        rst = 1'b1; upd_req = 1'b0; upd_done = 1'b0;
        team1_in = '0; team2_in = '0; ball_x_in = '0; ball_y_in = '0;
        test_reset();
        test_commit();
        test_wrap_abort();
        test_done_at_wrap();
        test_stray_done();
        test_reset_in_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
